// File: rtl/op_handler_dispatcher.sv
// Op handler dispatcher: accepts one decoded op per trigger, fires a
// one-cycle trigger at the mapped handler, waits for its done, and
// reports completion upstream, with an optional watchdog.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   trigger, op_in    upstream request and op word (sampled in IDLE)
//   busy, done, error status to upstream (error = forced by timeout)
//   handler_trigger   one-hot, one-cycle trigger to selected handler
//   handler_op        latched op broadcast to all handlers
//   handler_done      per-handler completion (level or pulse)
//   active_idx        index of the selected handler
module op_handler_dispatcher #(
    parameter int NUM_HANDLERS   = 3,
    parameter int CMD_W          = 4,
    parameter int OP_W           = 64,
    parameter int IDX_W          = (NUM_HANDLERS > 1) ? $clog2(NUM_HANDLERS) : 1,
    parameter logic [(2**CMD_W)*IDX_W-1:0] HANDLER_MAP = {
        {(2**CMD_W-4){IDX_W'(2)}},
        IDX_W'(1), IDX_W'(1), IDX_W'(0), IDX_W'(0)
    },
    parameter int DEFAULT_IDX    = NUM_HANDLERS - 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    trigger,
    input  logic [OP_W-1:0]         op_in,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [NUM_HANDLERS-1:0] handler_trigger,
    output logic [OP_W-1:0]         handler_op,
    input  logic [NUM_HANDLERS-1:0] handler_done,
    output logic [IDX_W-1:0]        active_idx
);

    localparam int CNT_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [NUM_HANDLERS-1:0] trig_q, trig_d;
    logic [OP_W-1:0]         op_q, op_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // Unpack the flat map into one entry per cmd value.
    logic [IDX_W-1:0] map_tbl [2**CMD_W];

    for (genvar c = 0; c < 2**CMD_W; c++) begin : g_map
        assign map_tbl[c] = HANDLER_MAP[c*IDX_W +: IDX_W];
    end

    logic [CMD_W-1:0]        cmd;
    logic [IDX_W-1:0]        raw_idx;
    logic [IDX_W-1:0]        sel_idx;
    logic [NUM_HANDLERS-1:0] done_sh;
    logic                    sel_done;
    logic                    timeout_hit;

    assign cmd     = op_in[CMD_W-1:0];
    assign raw_idx = map_tbl[cmd];

    // Out-of-range map entries fall back to the default handler.
    always_comb begin
        sel_idx = raw_idx;
        if (NUM_HANDLERS == 1) begin
            sel_idx = '0;
        end else if ({{(32-IDX_W){1'b0}}, raw_idx} >= 32'(NUM_HANDLERS)) begin
            sel_idx = IDX_W'(DEFAULT_IDX);
        end
    end

    // Only the selected handler's done bit is ever looked at.
    assign done_sh  = handler_done >> idx_q;
    assign sel_done = done_sh[0];

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        trig_d  = '0;
        op_d    = op_q;
        idx_d   = idx_q;
        cnt_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    op_d    = op_in;
                    idx_d   = sel_idx;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    trig_d  = NUM_HANDLERS'(1) << sel_idx;
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (sel_done) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A real done beats a simultaneous watchdog expiry.
                if (sel_done) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else if (timeout_hit) begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            trig_q  <= '0;
            op_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            trig_q  <= trig_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign handler_trigger = trig_q;
    assign handler_op      = op_q;
    assign active_idx      = idx_q;

endmodule

// File: tb/tb_op_handler_dispatcher.sv
// Testbench for op_handler_dispatcher: table of directed ops with
// hand-computed latencies plus reset, held-trigger and idle-done sequences.
module tb_op_handler_dispatcher;

    localparam int NH = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        trigger;
    logic [63:0] op_in;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  handler_trigger;
    logic [63:0] handler_op;
    logic [2:0]  handler_done;
    logic [1:0]  active_idx;

    int n_tests = 0;
    int n_fail  = 0;

    op_handler_dispatcher #(
        .NUM_HANDLERS  (NH),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .trigger        (trigger),
        .op_in          (op_in),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .handler_trigger(handler_trigger),
        .handler_op     (handler_op),
        .handler_done   (handler_done),
        .active_idx     (active_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_op(input int i, input logic [3:0] c);
        logic [31:0] mid;
        mid = 32'(i) * 32'h1357_9bdf;
        return {28'h0abcdef, mid, c};
    endfunction

    typedef struct {
        logic [3:0] cmd;
        int         hnd;
        int         dly;
        logic [2:0] trig;
        int         done_cyc;
        logic       err;
    } vec_t;

    vec_t vecs [10];

    // Starts at a negedge in IDLE; returns at the negedge of the cycle
    // after done (IDLE again). Cycle 0 = accept cycle.
    task automatic run_op(input logic [63:0] op, input int hnd,
                          input int dly, output logic [2:0] g_trig,
                          output int g_idx, output int g_done,
                          output logic g_err, output logic g_busy_after,
                          output logic g_err_idle, output int g_extra,
                          output logic g_hop_ok);
        trigger      = 1'b1;
        op_in        = op;
        handler_done = '0;
        g_trig       = '0;
        g_idx        = -1;
        g_done       = -1;
        g_err        = 1'b0;
        g_extra      = 0;
        g_hop_ok     = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            trigger = 1'b0;
            op_in   = ~op;
            if (dly >= 0 && c == 1 + dly)
                handler_done = 3'b001 << hnd;
            else
                handler_done = '0;
            if (c == 1) begin
                g_trig = handler_trigger;
                g_idx  = int'(active_idx);
            end else if (handler_trigger != '0) begin
                g_extra++;
            end
            if (handler_op !== op) g_hop_ok = 1'b0;
            if (done) begin
                g_done = c;
                g_err  = error;
                break;
            end
        end
        handler_done = '0;
        @(negedge clk);
        g_busy_after = busy;
        g_err_idle   = error;
    endtask

    logic [2:0]  g_trig;
    int          g_idx;
    int          g_done;
    logic        g_err;
    logic        g_busy_after;
    logic        g_err_idle;
    int          g_extra;
    logic        g_hop_ok;
    logic [63:0] op;
    int          extra;
    int          early;

    initial begin
        //         cmd    hnd dly trig    done err
        vecs[0] = '{4'd0,  0,  4, 3'b001,  6, 1'b0};
        vecs[1] = '{4'd2,  1,  0, 3'b010,  2, 1'b0};
        vecs[2] = '{4'd4,  2,  0, 3'b100,  2, 1'b0};
        vecs[3] = '{4'd1,  0,  0, 3'b001,  2, 1'b0};
        vecs[4] = '{4'd3,  1,  0, 3'b010,  2, 1'b0};
        vecs[5] = '{4'd5,  2,  0, 3'b100,  2, 1'b0};
        vecs[6] = '{4'd15, 2,  1, 3'b100,  3, 1'b0};
        vecs[7] = '{4'd1,  0, -1, 3'b001, 10, 1'b1};
        vecs[8] = '{4'd0,  0,  0, 3'b001,  2, 1'b0};
        vecs[9] = '{4'd2,  1,  8, 3'b010, 10, 1'b0};

        reset        = 1'b1;
        trigger      = 1'b0;
        op_in        = '0;
        handler_done = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_trig", 64'(handler_trigger), 64'd0);
        check("rst_op", handler_op, 64'd0);
        check("rst_idx", 64'(active_idx), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            op = mk_op(i, vecs[i].cmd);
            run_op(op, vecs[i].hnd, vecs[i].dly, g_trig, g_idx, g_done,
                   g_err, g_busy_after, g_err_idle, g_extra, g_hop_ok);
            check($sformatf("v%0d_trig", i), 64'(g_trig), 64'(vecs[i].trig));
            check($sformatf("v%0d_idx", i), 64'(g_idx), 64'(vecs[i].hnd));
            check($sformatf("v%0d_done_cyc", i), 64'(g_done),
                  64'(vecs[i].done_cyc));
            check($sformatf("v%0d_err", i), 64'(g_err), 64'(vecs[i].err));
            check($sformatf("v%0d_err_idle", i), 64'(g_err_idle),
                  64'(vecs[i].err));
            check($sformatf("v%0d_busy_after", i), 64'(g_busy_after), 64'd0);
            check($sformatf("v%0d_extra_trig", i), 64'(g_extra), 64'd0);
            check($sformatf("v%0d_hop_stable", i), 64'(g_hop_ok), 64'd1);
        end

        // Reset while waiting on a handler.
        trigger = 1'b1;
        op_in   = mk_op(20, 4'd0);
        @(negedge clk);
        trigger = 1'b0;
        repeat (2) @(negedge clk);
        check("wait_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("wrst_busy", 64'(busy), 64'd0);
        check("wrst_done", 64'(done), 64'd0);
        check("wrst_trig", 64'(handler_trigger), 64'd0);
        check("wrst_op", handler_op, 64'd0);
        check("wrst_idx", 64'(active_idx), 64'd0);
        run_op(mk_op(21, 4'd0), 0, 2, g_trig, g_idx, g_done, g_err,
               g_busy_after, g_err_idle, g_extra, g_hop_ok);
        check("post_rst_trig", 64'(g_trig), 64'b001);
        check("post_rst_done_cyc", 64'(g_done), 64'd4);

        // Trigger held high with foreign done bits toggling.
        op      = mk_op(30, 4'd2);
        trigger = 1'b1;
        op_in   = op;
        extra   = 0;
        early   = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1)
                check("hold_trig", 64'(handler_trigger), 64'b010);
            else if (handler_trigger != '0)
                extra++;
            if (c < 7 && done) early++;
            if (c == 7) begin
                check("hold_done", 64'(done), 64'd1);
                check("hold_err", 64'(error), 64'd0);
                trigger = 1'b0;
            end
            if (c == 8) check("hold_busy_after", 64'(busy), 64'd0);
            if (c < 6)
                handler_done = (c % 2 == 1) ? 3'b101 : 3'b000;
            else if (c == 6)
                handler_done = 3'b010;
            else
                handler_done = 3'b000;
        end
        check("hold_extra_trig", 64'(extra), 64'd0);
        check("hold_early_done", 64'(early), 64'd0);

        // Done levels while idle must be ignored.
        handler_done = 3'b111;
        repeat (2) @(negedge clk);
        check("idle_done_busy", 64'(busy), 64'd0);
        check("idle_done_done", 64'(done), 64'd0);
        handler_done = 3'b000;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/op_handler_dispatcher.md
Name: op_handler_dispatcher

Overview:
- Sequential, parametrised successor to the combinational op-to-handler chooser.
- Accepts one decoded op per handshake and latches it.
- Routes a one-cycle trigger to exactly one of NUM_HANDLERS handlers, selected through a cmd-indexed map.
- Waits for that handler's done, then reports completion upstream. A watchdog catches handlers that never finish.
- Sits between the op parser/queue and the linear/circular/dummy motion handlers.

Parameters:
- NUM_HANDLERS, 3, number of downstream handlers (min 1, max 16).
- CMD_W, 4, width of the op cmd field (low CMD_W bits of op_in).
- OP_W, 64, total op word width (cmd plus operand fields, opaque to this block).
- IDX_W, $clog2(NUM_HANDLERS) (min 1), handler index width.
- HANDLER_MAP, {2,2,...,2,2,1,1,0,0}, packed 2**CMD_W by IDX_W array; entry c is the handler index for cmd c.
  - Op_PKG encoding: G00=0, G01=1, G02=2, G03=3, G90=4, G91=5.
  - Default map: G00/G01 go to 0 (linear), G02/G03 go to 1 (circular), all other cmds go to 2 (dummy).
- DEFAULT_IDX, NUM_HANDLERS-1, used when a map entry is >= NUM_HANDLERS.
- TIMEOUT_CYCLES, 0, WAIT-state watchdog limit; 0 disables it.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- trigger  in  1  upstream request; sampled only in IDLE.
- op_in  in  OP_W  op word; sampled with trigger.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse to upstream.
- error  out  1  high with done when completion was forced by timeout; cleared on the next accepted trigger.
- handler_trigger  out  NUM_HANDLERS  one-hot, one-cycle trigger to the selected handler.
- handler_op  out  OP_W  latched op, broadcast to all handlers, stable from DISPATCH until the next accept.
- handler_done  in  NUM_HANDLERS  per-handler completion; level or pulse.
- active_idx  out  IDX_W  index of the selected handler, valid while busy.

Behaviour:
Reset values: busy=0, done=0, error=0, handler_trigger=0, handler_op=0, active_idx=0, state=IDLE, watchdog counter=0.

States:
- IDLE
  - If trigger=1: latch op_in into handler_op.
  - Compute idx = HANDLER_MAP[op_in[CMD_W-1:0]]; if idx >= NUM_HANDLERS, substitute DEFAULT_IDX.
  - Register idx into active_idx, clear error, go to DISPATCH.
- DISPATCH (exactly 1 cycle)
  - handler_trigger[active_idx]=1, all other bits 0.
  - If handler_done[active_idx]=1 this same cycle, go to FINISH; otherwise go to WAIT.
- WAIT
  - handler_trigger=0; the watchdog counter increments each cycle.
  - If handler_done[active_idx]=1, go to FINISH.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1, set error=1 and go to FINISH.
  - handler_done wins over timeout when both occur in the same cycle (error stays 0).
- FINISH (1 cycle)
  - done=1, then go to IDLE; the counter clears.
  - busy drops in the cycle after FINISH.

Latency and throughput:
- Trigger accepted at cycle 0 gives the handler trigger at cycle 1.
- With handler_done in cycle k>=1, the done pulse is at cycle k+1.
- Minimum accept-to-accept spacing is 3 cycles (trigger, DISPATCH, FINISH).

Boundary rules:
- trigger while busy is ignored and not queued; upstream must hold or re-issue it.
- handler_done bits of non-selected handlers are ignored in all states.
- handler_done in IDLE is ignored.
- A handler_done level held high from a previous op must not complete the new op before its DISPATCH cycle; only DISPATCH/WAIT sample it.
- Reset asserted in any state: at the next edge return to IDLE with all outputs at reset values. No trigger or done pulse is emitted on that edge.
- NUM_HANDLERS=1: every cmd routes to handler 0.
- op_in changing while busy has no effect on handler_op.

Test Plan:
- Reset, then trigger with G00 (cmd=0); handler 0 raises done 4 cycles after its trigger -> handler_trigger=3'b001 for 1 cycle at cycle 1; done=1 at cycle 6; error=0; active_idx=0.
- Sequence G02, G90, G01, G03, G91 with immediate done -> trigger bits 010, 100, 001, 010, 100 respectively; 3 cycles per op; busy low between ops.
- Trigger held high while a circular op is in WAIT, with handler 0/2 done toggling -> no re-accept and no early completion; completes only on handler_done[1].
- TIMEOUT_CYCLES=8, G01 with handler never done -> done and error both 1 at cycle 10 after accept. The next trigger clears error.
- Handler done and the watchdog expiry coincide -> done=1, error=0.
- Reset asserted during WAIT -> next cycle busy=0, done=0, handler_trigger=0; a subsequent G00 dispatches normally.
